pattern_serializer: RTL and testbench

Serial transmitter that produces the bit stream consumed by `pattern_detector`. It accepts parallel words over a valid/ready handshake and emits one frame per word: the 5-bit sync pattern `11010`, then the payload MSB first, one bit per clock. It sits upstream of the detector, and the two are paired in loopback benches.

---
 rtl/pattern_serializer.sv | 122 ++++++++++++
 tb/tb_pattern_serializer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pattern_serializer.sv
// Serial framer: sync pattern then payload MSB first, one bit per clock, over a valid/ready handshake.
// Optional trailing even-parity bit when PATTERN_SERIALIZER_PARITY_EN is defined.
module pattern_serializer #(
  parameter int unsigned         DATA_WIDTH   = 8,
  parameter int unsigned         SYNC_LEN     = 5,
  parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = 5'b11010
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  stream_out,
  output logic                  frame_active
);

  localparam int unsigned MAX_LEN = (SYNC_LEN > DATA_WIDTH) ? SYNC_LEN : DATA_WIDTH;
  localparam int unsigned CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_LEN - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
`ifdef PATTERN_SERIALIZER_PARITY_EN
    DATA = 2'd2,
    PARITY = 2'd3
`else
    DATA = 2'd2
`endif
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [SYNC_LEN-1:0]   syncsh;
  logic                  accept;
`ifdef PATTERN_SERIALIZER_PARITY_EN
  logic                  parity;
`endif

  always_comb begin
    data_ready = 1'b0;
    case (state)
      IDLE:   data_ready = 1'b1;
`ifdef PATTERN_SERIALIZER_PARITY_EN
      PARITY: data_ready = 1'b1;
`else
      DATA:   data_ready = (cnt == DATA_LAST);
`endif
      default: data_ready = 1'b0;
    endcase
  end

  assign accept = data_valid && data_ready;

  // Accept is only possible in IDLE or on the final frame bit, so it takes
  // priority and doubles as the zero-gap restart path.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      shreg        <= '0;
      syncsh       <= '0;
      stream_out   <= 1'b0;
      frame_active <= 1'b0;
`ifdef PATTERN_SERIALIZER_PARITY_EN
      parity       <= 1'b0;
`endif
    end else if (accept) begin
      state        <= SYNC;
      cnt          <= '0;
      shreg        <= data_in;
      syncsh       <= SYNC_PATTERN << 1;
      stream_out   <= SYNC_PATTERN[SYNC_LEN-1];
      frame_active <= 1'b1;
`ifdef PATTERN_SERIALIZER_PARITY_EN
      parity       <= ^data_in;
`endif
    end else begin
      case (state)
        SYNC: begin
          if (cnt == SYNC_LAST) begin
            state      <= DATA;
            cnt        <= '0;
            stream_out <= shreg[DATA_WIDTH-1];
            shreg      <= shreg << 1;
          end else begin
            cnt        <= cnt + CW'(1);
            stream_out <= syncsh[SYNC_LEN-1];
            syncsh     <= syncsh << 1;
          end
        end
        DATA: begin
          if (cnt == DATA_LAST) begin
`ifdef PATTERN_SERIALIZER_PARITY_EN
            state      <= PARITY;
            cnt        <= '0;
            stream_out <= parity;
`else
            state        <= IDLE;
            cnt          <= '0;
            stream_out   <= 1'b0;
            frame_active <= 1'b0;
`endif
          end else begin
            cnt        <= cnt + CW'(1);
            stream_out <= shreg[DATA_WIDTH-1];
            shreg      <= shreg << 1;
          end
        end
        default: begin
          state        <= IDLE;
          cnt          <= '0;
          stream_out   <= 1'b0;
          frame_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_serializer.sv
// Scoreboard bench for pattern_serializer: expected frame bits are queued when a word is driven
// and popped as the line is sampled on the falling edge.
module tb_pattern_serializer;

  localparam int unsigned DW = 8;
  localparam int unsigned SL = 5;
`ifdef PATTERN_SERIALIZER_PARITY_EN
  localparam int unsigned FL = SL + DW + 1;
`else
  localparam int unsigned FL = SL + DW;
`endif

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          data_valid = 1'b0;
  logic          data_ready;
  logic          stream_out;
  logic          frame_active;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic exp_q[$];
  logic exp_bit;
  logic [SL-1:0] sync_pat = 5'b11010;

  pattern_serializer #(
    .DATA_WIDTH  (DW),
    .SYNC_LEN    (SL),
    .SYNC_PATTERN(5'b11010)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .stream_out  (stream_out),
    .frame_active(frame_active)
  );

  always #5 clk = ~clk;

  // Reference framing: sync MSB first, payload MSB first, optional even parity.
  function automatic void push_frame(input logic [DW-1:0] d);
    for (int k = SL - 1; k >= 0; k--) exp_q.push_back(sync_pat[k]);
    for (int k = DW - 1; k >= 0; k--) exp_q.push_back(d[k]);
`ifdef PATTERN_SERIALIZER_PARITY_EN
    exp_q.push_back(^d);
`endif
  endfunction

  task automatic test_reset();
    n_rst = 1'b0;
    data_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total_cnt++;
      if ({stream_out, frame_active, data_ready} !== 3'b001)
        $display("FAIL reset_idle cycle %0d: out/active/ready=%b%b%b expected 001", i, stream_out, frame_active, data_ready);
      else pass_cnt++;
    end
  endtask

  // Samples n cycles at the falling edge; queue contents define the expected line.
  task automatic test_single(input logic [DW-1:0] d, input string name);
    @(negedge clk);
    data_in = d;
    data_valid = 1'b1;
    push_frame(d);
    @(negedge clk);
    data_valid = 1'b0;
    data_in = ~d;
    for (int i = 0; i < FL + 3; i++) begin
      if (i > 0) @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_bit = exp_q.pop_front();
        total_cnt++;
        if (stream_out !== exp_bit || frame_active !== 1'b1)
          $display("FAIL %s bit %0d: out=%b active=%b expected out=%b active=1", name, i, stream_out, frame_active, exp_bit);
        else pass_cnt++;
        total_cnt++;
        if (data_ready !== (i == FL - 1))
          $display("FAIL %s ready %0d: got %b expected %b", name, i, data_ready, (i == FL - 1));
        else pass_cnt++;
      end else begin
        total_cnt++;
        if ({stream_out, frame_active, data_ready} !== 3'b001)
          $display("FAIL %s idle %0d: out/active/ready=%b%b%b expected 001", name, i, stream_out, frame_active, data_ready);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    data_in = 8'hA5;
    data_valid = 1'b1;
    push_frame(8'hA5);
    @(negedge clk);
    // Second word pending with valid held high while ready is low.
    data_in = 8'h3C;
    push_frame(8'h3C);
    for (int i = 0; i < 2 * FL + 2; i++) begin
      if (i > 0) @(negedge clk);
      if (i < 2 * FL) begin
        exp_bit = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
        total_cnt++;
        if (stream_out !== exp_bit || frame_active !== 1'b1)
          $display("FAIL b2b bit %0d: out=%b active=%b expected out=%b active=1", i, stream_out, frame_active, exp_bit);
        else pass_cnt++;
        total_cnt++;
        if (data_ready !== (i == FL - 1 || i == 2 * FL - 1))
          $display("FAIL b2b ready %0d: got %b expected %b", i, data_ready, (i == FL - 1 || i == 2 * FL - 1));
        else pass_cnt++;
        if (i == 2 * FL - 1) data_valid = 1'b0;
      end else begin
        total_cnt++;
        if ({stream_out, frame_active, data_ready} !== 3'b001)
          $display("FAIL b2b idle %0d: out/active/ready=%b%b%b expected 001", i, stream_out, frame_active, data_ready);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    data_in = 8'hFF;
    data_valid = 1'b1;
    push_frame(8'hFF);
    @(negedge clk);
    data_valid = 1'b0;
    for (int i = 0; i <= SL + 3; i++) begin
      if (i > 0) @(negedge clk);
      exp_bit = exp_q.pop_front();
      total_cnt++;
      if (stream_out !== exp_bit || frame_active !== 1'b1)
        $display("FAIL midrst bit %0d: out=%b active=%b expected out=%b active=1", i, stream_out, frame_active, exp_bit);
      else pass_cnt++;
    end
    #2 n_rst = 1'b0;
    exp_q.delete();
    #1;
    total_cnt++;
    if ({stream_out, frame_active, data_ready} !== 3'b001)
      $display("FAIL midrst async: out/active/ready=%b%b%b expected 001", stream_out, frame_active, data_ready);
    else pass_cnt++;
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < FL + 2; i++) begin
      @(negedge clk);
      total_cnt++;
      if ({stream_out, frame_active, data_ready} !== 3'b001)
        $display("FAIL midrst after %0d: out/active/ready=%b%b%b expected 001", i, stream_out, frame_active, data_ready);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single(8'hA5, "single_a5");
    test_single(8'hA4, "single_a4");
    test_single(8'h00, "single_00");
    test_single(8'hFF, "single_ff");
    test_back_to_back();
    test_reset_mid_frame();
    test_single(8'h1A, "after_rst");
    for (int r = 0; r < 3; r++) test_single(DW'($urandom_range(0, 255)), "random");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
